// File: rtl/axi4l_cmd_master_if.sv
// Command/response stream plus AXI4-Lite bus seen by axi4l_cmd_master.
// master = initiator view; slave = requester and responder view.
interface axi4l_cmd_master_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_wstrb;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [1:0]        rsp_resp;
  logic [DATA_W-1:0] rsp_rdata;

  logic [ADDR_W-1:0] AWADDR;
  logic [2:0]        AWPROT;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [2:0]        ARPROT;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
    output cmd_ready, rsp_valid, rsp_write, rsp_resp, rsp_rdata,
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARPROT, ARVALID, RREADY
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
    input  cmd_ready, rsp_valid, rsp_write, rsp_resp, rsp_rdata,
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARPROT, ARVALID, RREADY
  );
endinterface

// File: rtl/axi4l_cmd_master.sv
// AXI4-Lite initiator: one outstanding command at a time, with wrapping counters.
// Optional AXI4L_MST_ALIGN_CHECK_EN answers misaligned commands locally with SLVERR.
module axi4l_cmd_master #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter logic [2:0]  PROT   = 3'b000,
  parameter int unsigned CNT_W  = 16
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  axi4l_cmd_master_if.master bus,
  output logic               busy,
  output logic [CNT_W-1:0]   wr_count,
  output logic [CNT_W-1:0]   rd_count,
  output logic [CNT_W-1:0]   err_count
);
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {StIdle, StWr, StWrResp, StRd, StRdData, StRsp} state_e;

  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              cmd_fire, rsp_fire, misaligned;

  assign cmd_fire = cmd_ready_q & bus.cmd_valid;
  assign rsp_fire = rsp_valid_q & bus.rsp_ready;

`ifdef AXI4L_MST_ALIGN_CHECK_EN
  assign misaligned = |bus.cmd_addr[1:0];
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_write_d = rsp_write_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_rdata_d = rsp_rdata_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    err_cnt_d   = err_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          addr_d      = bus.cmd_addr;
          wdata_d     = bus.cmd_wdata;
          wstrb_d     = bus.cmd_wstrb;
          rsp_write_d = bus.cmd_write;
          if (misaligned) begin
            rsp_resp_d  = 2'b10;
            rsp_rdata_d = '0;
            state_d     = StRsp;
          end else if (bus.cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
            state_d   = StWr;
          end else begin
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
            state_d   = StRd;
          end
        end
      end
      StWr: begin
        if (bus.AWREADY) awvalid_d = 1'b0;
        if (bus.WREADY)  wvalid_d  = 1'b0;
        // Both channels done; take B directly if it shows up in the same cycle.
        if (!awvalid_d && !wvalid_d) begin
          if (bus.BVALID) begin
            rsp_resp_d  = bus.BRESP;
            rsp_rdata_d = '0;
            bready_d    = 1'b0;
            state_d     = StRsp;
          end else begin
            state_d = StWrResp;
          end
        end
      end
      StWrResp: begin
        if (bus.BVALID) begin
          rsp_resp_d  = bus.BRESP;
          rsp_rdata_d = '0;
          bready_d    = 1'b0;
          state_d     = StRsp;
        end
      end
      StRd: begin
        if (bus.ARREADY) begin
          arvalid_d = 1'b0;
          if (bus.RVALID) begin
            rsp_resp_d  = bus.RRESP;
            rsp_rdata_d = bus.RDATA;
            rready_d    = 1'b0;
            state_d     = StRsp;
          end else begin
            state_d = StRdData;
          end
        end
      end
      StRdData: begin
        if (bus.RVALID) begin
          rsp_resp_d  = bus.RRESP;
          rsp_rdata_d = bus.RDATA;
          rready_d    = 1'b0;
          state_d     = StRsp;
        end
      end
      StRsp: begin
        if (rsp_fire) begin
          if (rsp_write_q) wr_cnt_d = wr_cnt_q + CNT_W'(1);
          else             rd_cnt_d = rd_cnt_q + CNT_W'(1);
          if (rsp_resp_q != 2'b00) err_cnt_d = err_cnt_q + CNT_W'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    cmd_ready_d = (state_d == StIdle);
    rsp_valid_d = (state_d == StRsp);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_resp_q  <= 2'b00;
      rsp_rdata_q <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_rdata_q <= rsp_rdata_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_resp  = rsp_resp_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.AWADDR    = addr_q;
  assign bus.AWPROT    = PROT;
  assign bus.AWVALID   = awvalid_q;
  assign bus.WDATA     = wdata_q;
  assign bus.WSTRB     = wstrb_q;
  assign bus.WVALID    = wvalid_q;
  assign bus.BREADY    = bready_q;
  assign bus.ARADDR    = addr_q;
  assign bus.ARPROT    = PROT;
  assign bus.ARVALID   = arvalid_q;
  assign bus.RREADY    = rready_q;

  assign busy      = (state_q != StIdle);
  assign wr_count  = wr_cnt_q;
  assign rd_count  = rd_cnt_q;
  assign err_count = err_cnt_q;
endmodule

// File: tb/tb_axi4l_cmd_master.sv
// Directed bench for axi4l_cmd_master: table of transactions against a scripted
// AXI4-Lite responder, plus reset, backpressure and counter-wrap sequences.
module tb_axi4l_cmd_master;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;  // narrow so wrap-around is reachable quickly

  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  sresp;   // BRESP or RRESP returned by the responder
    logic [31:0] srdata;  // RDATA driven by the responder
    int          aw_dly;
    int          w_dly;
    int          ar_dly;
    logic        early;   // B/R presented in the same cycle as the last address/data handshake
    int          hold;    // cycles rsp_ready is held low after rsp_valid
    logic        axi;     // 1 if an AXI transaction is expected
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } txn_t;

  logic             ACLK = 1'b0;
  logic             ARESETN = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] wr_count, rd_count, err_count;
  logic [CNT_W-1:0] wr_exp = '0, rd_exp = '0, err_exp = '0;
  int               checks = 0;
  int               failures = 0;
  txn_t             tbl [9];

  axi4l_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi4l_cmd_master #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .PROT  (3'b000),
    .CNT_W (CNT_W)
  ) dut (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .bus      (bus),
    .busy     (busy),
    .wr_count (wr_count),
    .rd_count (rd_count),
    .err_count(err_count)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic slave_idle();
    bus.AWREADY = 1'b0;
    bus.WREADY  = 1'b0;
    bus.BVALID  = 1'b0;
    bus.BRESP   = 2'b00;
    bus.ARREADY = 1'b0;
    bus.RVALID  = 1'b0;
    bus.RDATA   = '0;
    bus.RRESP   = 2'b00;
  endtask

  task automatic check_counters(input string tag);
    check({tag, " wr_count"}, 64'(wr_count), 64'(wr_exp));
    check({tag, " rd_count"}, 64'(rd_count), 64'(rd_exp));
    check({tag, " err_count"}, 64'(err_count), 64'(err_exp));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " valids/readies/busy"},
          64'({bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY,
               bus.cmd_ready, bus.rsp_valid, busy}), 64'd0);
    check({tag, " addr/strb/prot"},
          64'({bus.AWADDR, bus.ARADDR, bus.WSTRB, bus.AWPROT, bus.ARPROT}), 64'd0);
    check({tag, " wdata"}, 64'(bus.WDATA), 64'd0);
    check({tag, " rsp fields"}, 64'({bus.rsp_write, bus.rsp_resp, bus.rsp_rdata}), 64'd0);
    check({tag, " counters"}, 64'({wr_count, rd_count, err_count}), 64'd0);
  endtask

  task automatic run_txn(input txn_t t, input string tag);
    int  k, lat, viol, aw_hs, w_hs, ar_hs, b_hs, r_hs;
    bit  got, aw_done, w_done, ar_done, b_done, r_done;
    bit  aw_now, w_now, ar_now, b_now, r_now;
    k = 0;
    while (!bus.cmd_ready && k < 20) begin
      tick();
      k++;
    end
    if (!bus.cmd_ready) begin
      check({tag, " cmd_ready wait"}, 64'(bus.cmd_ready), 64'd1);
      return;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_write = t.write;
    bus.cmd_addr  = t.addr;
    bus.cmd_wdata = t.wdata;
    bus.cmd_wstrb = t.wstrb;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_wdata = 32'h0;
    {viol, aw_hs, w_hs, ar_hs, b_hs, r_hs, lat} = '0;
    {got, aw_done, w_done, ar_done, b_done, r_done} = '0;
    k = 1;
    while (!got && k <= 40) begin
      if (bus.rsp_valid) begin
        got = 1'b1;
        lat = k;
      end else begin
        if (bus.cmd_ready || !busy) viol++;
        if (t.write && t.axi && !aw_done && !bus.AWVALID) viol++;
        if (t.write && t.axi && !w_done && !bus.WVALID) viol++;
        if (!t.write && t.axi && !ar_done && !bus.ARVALID) viol++;
        if (bus.AWVALID && (bus.AWADDR !== t.addr || bus.AWPROT !== 3'b000)) viol++;
        if (bus.WVALID && (bus.WDATA !== t.wdata || bus.WSTRB !== t.wstrb)) viol++;
        if (bus.ARVALID && (bus.ARADDR !== t.addr || bus.ARPROT !== 3'b000)) viol++;
        bus.AWREADY = (k >= 1 + t.aw_dly);
        bus.WREADY  = (k >= 1 + t.w_dly);
        bus.ARREADY = (k >= 1 + t.ar_dly);
        aw_now = bus.AWVALID && bus.AWREADY;
        w_now  = bus.WVALID && bus.WREADY;
        ar_now = bus.ARVALID && bus.ARREADY;
        bus.BVALID = !b_done && (t.early ? ((aw_done || aw_now) && (w_done || w_now))
                                         : (aw_done && w_done));
        bus.BRESP  = t.sresp;
        bus.RVALID = !r_done && (t.early ? (ar_done || ar_now) : ar_done);
        bus.RDATA  = t.srdata;
        bus.RRESP  = t.sresp;
        b_now = bus.BVALID && bus.BREADY;
        r_now = bus.RVALID && bus.RREADY;
        aw_hs += int'(aw_now);
        w_hs  += int'(w_now);
        ar_hs += int'(ar_now);
        b_hs  += int'(b_now);
        r_hs  += int'(r_now);
        aw_done |= aw_now;
        w_done  |= w_now;
        ar_done |= ar_now;
        b_done  |= b_now;
        r_done  |= r_now;
        tick();
        k++;
      end
    end
    slave_idle();
    check({tag, " rsp_valid seen"}, 64'(got), 64'd1);
    if (!got) return;
    check({tag, " latency"}, 64'(lat), 64'(t.exp_lat));
    check({tag, " rsp_write"}, 64'(bus.rsp_write), 64'(t.write));
    check({tag, " rsp_resp"}, 64'(bus.rsp_resp), 64'(t.exp_resp));
    check({tag, " rsp_rdata"}, 64'(bus.rsp_rdata), 64'(t.exp_rdata));
    check({tag, " aw/w/b handshakes"}, 64'({aw_hs[7:0], w_hs[7:0], b_hs[7:0]}),
          (t.write && t.axi) ? 64'h010101 : 64'h0);
    check({tag, " ar/r handshakes"}, 64'({ar_hs[7:0], r_hs[7:0]}),
          (!t.write && t.axi) ? 64'h0101 : 64'h0);
    check({tag, " protocol"}, 64'(viol), 64'd0);
    if (t.hold > 0) begin
      viol = 0;
      for (int h = 0; h < t.hold; h++) begin
        if (!bus.rsp_valid || bus.cmd_ready || bus.rsp_write !== t.write ||
            bus.rsp_resp !== t.exp_resp || bus.rsp_rdata !== t.exp_rdata) viol++;
        tick();
      end
      check({tag, " rsp stable under backpressure"}, 64'(viol), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    if (t.write) wr_exp++;
    else         rd_exp++;
    if (t.exp_resp != 2'b00) err_exp++;
    check({tag, " after rsp: cmd_ready/rsp_valid/busy"},
          64'({bus.cmd_ready, bus.rsp_valid, busy}), 64'b100);
    check_counters(tag);
  endtask

  initial begin
    //          wr    addr   wdata         strb  sresp  srdata        aw w ar early hold axi eresp  erdata        lat
    tbl[0] = '{1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'h11111111, 0, 0, 0, 1'b0, 0, 1'b1, 2'b00, 32'h0,        3};
    tbl[1] = '{1'b0, 8'h08, 32'h0,        4'h0, 2'b00, 32'h12345678, 0, 0, 0, 1'b0, 0, 1'b1, 2'b00, 32'h12345678, 3};
    tbl[2] = '{1'b1, 8'h10, 32'hA5A5A5A5, 4'h3, 2'b00, 32'h22222222, 0, 3, 0, 1'b0, 0, 1'b1, 2'b00, 32'h0,        6};
    tbl[3] = '{1'b1, 8'h14, 32'h5A5A0F0F, 4'hC, 2'b00, 32'h0,        3, 0, 0, 1'b0, 0, 1'b1, 2'b00, 32'h0,        6};
    tbl[4] = '{1'b0, 8'h20, 32'h0,        4'h0, 2'b10, 32'hCAFEF00D, 0, 0, 0, 1'b0, 5, 1'b1, 2'b10, 32'hCAFEF00D, 3};
    tbl[5] = '{1'b1, 8'h30, 32'h01020304, 4'h5, 2'b11, 32'h0,        1, 1, 0, 1'b1, 2, 1'b1, 2'b11, 32'h0,        3};
    tbl[6] = '{1'b0, 8'h3C, 32'h0,        4'h0, 2'b00, 32'h87654321, 0, 0, 2, 1'b1, 0, 1'b1, 2'b00, 32'h87654321, 4};
    tbl[7] = '{1'b0, 8'hFC, 32'h0,        4'h0, 2'b01, 32'hFFFF0000, 0, 0, 0, 1'b0, 1, 1'b1, 2'b01, 32'hFFFF0000, 3};
`ifdef AXI4L_MST_ALIGN_CHECK_EN
    tbl[8] = '{1'b0, 8'h05, 32'h0,        4'h0, 2'b00, 32'h0BADF00D, 0, 0, 0, 1'b0, 0, 1'b0, 2'b10, 32'h0,        1};
`else
    tbl[8] = '{1'b0, 8'h05, 32'h0,        4'h0, 2'b00, 32'h0BADF00D, 0, 0, 0, 1'b0, 0, 1'b1, 2'b00, 32'h0BADF00D, 3};
`endif

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_wstrb = '0;
    bus.rsp_ready = 1'b0;
    slave_idle();

    // Reset state, then cmd_ready one cycle after release.
    repeat (3) tick();
    check_all_zero("reset");
    ARESETN = 1'b1;
    check("cmd_ready at release", 64'(bus.cmd_ready), 64'd0);
    tick();
    check("cmd_ready after release", 64'(bus.cmd_ready), 64'd1);

    for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("t%0d", i));

    // Sixteen zero-wait writes: wr_count must wrap back to the same value.
    for (int i = 0; i < 16; i++) run_txn(tbl[0], $sformatf("wrap%0d", i));

    // Reset while AWVALID is pending.
    while (!bus.cmd_ready) tick();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'h44;
    bus.cmd_wdata = 32'h55AA55AA;
    bus.cmd_wstrb = 4'hF;
    tick();
    bus.cmd_valid = 1'b0;
    check("mid-write AWVALID/WVALID", 64'({bus.AWVALID, bus.WVALID}), 64'b11);
    ARESETN = 1'b0;
    tick();
    check_all_zero("mid-write reset");
    wr_exp  = '0;
    rd_exp  = '0;
    err_exp = '0;
    ARESETN = 1'b1;
    check("cmd_ready at re-release", 64'(bus.cmd_ready), 64'd0);
    tick();
    check("cmd_ready after re-release", 64'(bus.cmd_ready), 64'd1);
    run_txn(tbl[1], "post-reset read");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi4l_cmd_master.md
Name: axi4l_cmd_master

Overview:
- AXI4-Lite initiator. Converts a simple command/response stream from the processing-side sequencer into AXI4-Lite read and write transactions.
- Drives the same 8-bit-address, 32-bit-data AXI4-Lite interface that the register-file responder terminates.
- Handles one outstanding transaction at a time. Returns BRESP/RRESP and read data to the requester, and keeps wrapping transaction and error counters.

Parameters:
- ADDR_W, 8, address width of AWADDR/ARADDR/cmd_addr.
- DATA_W, 32, data width of WDATA/RDATA/cmd_wdata/rsp_rdata; WSTRB width is DATA_W/8.
- PROT, 3'b000, constant driven on AWPROT and ARPROT.
- CNT_W, 16, width of the wr_count, rd_count and err_count counters.

Ports:
- ACLK in 1: clock.
- ARESETN in 1: synchronous active-low reset.
- cmd_valid in 1: command valid.
- cmd_ready out 1: command accepted when cmd_valid && cmd_ready.
- cmd_write in 1: 1 = write, 0 = read.
- cmd_addr in ADDR_W: byte address.
- cmd_wdata in DATA_W: write data.
- cmd_wstrb in DATA_W/8: write strobes.
- rsp_valid out 1: response valid.
- rsp_ready in 1: response consumed when rsp_valid && rsp_ready.
- rsp_write out 1: echo of cmd_write.
- rsp_resp out 2: BRESP or RRESP.
- rsp_rdata out DATA_W: RDATA for reads, 0 for writes.
- AWADDR out ADDR_W, AWPROT out 3, AWVALID out 1, AWREADY in 1: write address channel.
- WDATA out DATA_W, WSTRB out DATA_W/8, WVALID out 1, WREADY in 1: write data channel.
- BRESP in 2, BVALID in 1, BREADY out 1: write response channel.
- ARADDR out ADDR_W, ARPROT out 3, ARVALID out 1, ARREADY in 1: read address channel.
- RDATA in DATA_W, RRESP in 2, RVALID in 1, RREADY out 1: read data channel.
- busy out 1: high in any state other than IDLE.
- wr_count, rd_count, err_count out CNT_W each: transaction and error counters.

Behaviour:
- Clocking and reset: single clock ACLK. Reset is synchronous and active-low on ARESETN, sampled on the ACLK rising edge.
- Reset values:
  - All VALID outputs, BREADY, RREADY, cmd_ready, rsp_valid and busy = 0.
  - All address, data, strobe and response outputs = 0.
  - All counters = 0.
  - State = IDLE.
- cmd_ready is registered. It is 1 in IDLE from the first cycle after ARESETN rises, and 0 in all other states.
- State machine: IDLE, WR, WR_RESP, RD, RD_DATA, RSP.
- IDLE, command accepted in cycle N:
  - Address, data and strobes are latched.
  - Write: AWVALID = WVALID = BREADY = 1 from cycle N+1; state WR.
  - Read: ARVALID = RREADY = 1 from cycle N+1; state RD.
- WR:
  - AWVALID drops the cycle after the AW handshake; WVALID drops the cycle after the W handshake. Each channel is dropped independently.
  - The two handshakes may occur in the same cycle or in either order.
  - Once both have completed, go to WR_RESP. If BVALID arrives in the same cycle as the final handshake, capture it directly.
- WR_RESP: on BVALID && BREADY, capture BRESP, drop BREADY, go to RSP.
- RD: on the AR handshake, drop ARVALID and go to RD_DATA. If RVALID arrives in the same cycle, capture it directly.
- RD_DATA: on RVALID && RREADY, capture RDATA/RRESP, drop RREADY, go to RSP.
- RSP:
  - rsp_valid = 1, with rsp_* held stable until rsp_ready.
  - On handshake, go to IDLE; cmd_ready = 1 on the following cycle.
- AXI rules:
  - A VALID is never deasserted before its handshake.
  - Address, data and strobe outputs are stable while their VALID is high.
  - No VALID depends combinationally on a READY.
- Minimum latency: command accept to rsp_valid is 3 cycles with zero-wait-state slave responses.
- Counters:
  - wr_count increments on each completed write response handshake; rd_count increments on each completed read response handshake.
  - err_count increments when rsp_resp != 2'b00.
  - All counters wrap at 2^CNT_W, with no saturation.
- Reset mid-transaction: the next cycle returns every output to its reset value. In-flight data is discarded.

Optional Feature:
- Macro: AXI4L_MST_ALIGN_CHECK_EN.
- Defined:
  - A command with cmd_addr[1:0] != 0 issues no AXI transaction.
  - The block goes IDLE -> RSP directly with rsp_resp = 2'b10 (SLVERR) and rsp_rdata = 0; rsp_valid is asserted at N+1.
  - err_count and the matching wr_count/rd_count increment.
- Undefined: the address is passed through unchanged and no local check is made.

Test Plan:
- Write with zero-wait slave: cmd write addr 0x04, data 0xDEADBEEF, strb 0xF -> AWVALID and WVALID at N+1; BRESP 00; rsp_valid at N+3, rsp_resp 00; wr_count = 1.
- Read with zero-wait slave: cmd read addr 0x08, slave returns 0x12345678 with RRESP 00 -> rsp_rdata 0x12345678; rd_count = 1; err_count = 0.
- Skewed write handshakes: slave AWREADY at cycle 1 and WREADY at cycle 4; then reversed order -> each VALID held until its own handshake; single B accepted; rsp_resp 00 in both cases.
- Error and backpressure: slave RRESP 10 and rsp_ready held low for 5 cycles -> rsp_valid and rsp_* stable for 5 cycles; err_count = 1; cmd_ready stays 0 until the cycle after the rsp handshake.
- Reset mid-write: ARESETN low while AWVALID = 1 -> next cycle all outputs and counters 0; after release, cmd_ready = 1 one cycle later.
- AXI4L_MST_ALIGN_CHECK_EN defined: cmd read addr 0x05 -> no ARVALID; rsp_resp 10 at N+1; err_count = 1.
